// File: rtl/seq_logic_pkg.sv
// Shared state encodings for small sequential control blocks.
// Debounce FSM: two stable levels and two counting states between them.
package seq_logic_pkg;

   typedef enum logic [1:0] {
      IDLE_LO = 2'b00,
      WAIT_HI = 2'b01,
      IDLE_HI = 2'b10,
      WAIT_LO = 2'b11
   } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Latency two edges; no flow control.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/debounce_edge.sv
// Debounces a raw level and emits one-cycle rise/fall pulses aligned with q_db.
// A clean step shows on q_db STABLE_CYCLES+2 edges after d_in changes; no flow control.
module debounce_edge
   import seq_logic_pkg::*;
#(
   parameter int STABLE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic q_db,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s;
   db_state_t        state;
   logic [CNT_W-1:0] cnt;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (d_in),
      .q   (s)
   );

   // cnt counts samples of the new level already seen, so it tops out at CNT_LAST
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE_LO;
         cnt   <= '0;
         q_db  <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            IDLE_LO: begin
               if (s) begin
                  state <= WAIT_HI;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt   <= '0;
               end
            end
            WAIT_HI: begin
               if (!s) begin
                  state <= IDLE_LO;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE_HI;
                  q_db  <= 1'b1;
                  rise  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + CNT_ONE;
               end
            end
            IDLE_HI: begin
               if (!s) begin
                  state <= WAIT_LO;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt   <= '0;
               end
            end
            WAIT_LO: begin
               if (s) begin
                  state <= IDLE_HI;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE_LO;
                  q_db  <= 1'b0;
                  fall  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= IDLE_LO;
               cnt   <= '0;
               q_db  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge at STABLE_CYCLES=4 and the minimum of 2.
// Each step queues the expected {q_db,rise,fall} for both instances and checks after the edge.
module tb_debounce_edge;

   logic clk = 1'b0;
   logic rst;
   logic d4, d2;
   logic q4, r4, f4;
   logic q2, r2, f2;

   int vectors     = 0;
   int miscompares = 0;

   logic [5:0] sb[$];

   always #5 clk = ~clk;

   debounce_edge #(.STABLE_CYCLES(4)) dut4 (
      .clk  (clk),
      .rst  (rst),
      .d_in (d4),
      .q_db (q4),
      .rise (r4),
      .fall (f4)
   );

   debounce_edge #(.STABLE_CYCLES(2)) dut2 (
      .clk  (clk),
      .rst  (rst),
      .d_in (d2),
      .q_db (q2),
      .rise (r2),
      .fall (f2)
   );

   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s got {q,rise,fall}=%b expected %b", tag, got, exp);
      end
   endtask

   // e4/e2 are the {q_db,rise,fall} values expected right after this edge
   task automatic step(input string tag, input logic d4v, input logic d2v, input logic rv,
                       input logic [2:0] e4, input logic [2:0] e2);
      logic [5:0] e;
      d4  = d4v;
      d2  = d2v;
      rst = rv;
      sb.push_back({e4, e2});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({tag, "/s4"}, {q4, r4, f4}, e[5:3]);
      check({tag, "/s2"}, {q2, r2, f2}, e[2:0]);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      d4 = 1'b0; d2 = 1'b0; rst = 1'b1;

      // reset state
      for (int i = 0; i < 2; i++) step("reset", 1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
      for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);

      // clean rise: q_db and rise after edge 5, rise gone after edge 6
      for (int i = 0; i < 8; i++)
         step("clean_rise", 1'b1, 1'b0, 1'b0, {i >= 5, i == 5, 1'b0}, 3'b000);

      // clean fall
      for (int i = 0; i < 8; i++)
         step("clean_fall", 1'b0, 1'b0, 1'b0, {i < 5, 1'b0, i == 5}, 3'b000);

      // 3-cycle glitch never completes the count
      for (int i = 0; i < 11; i++)
         step("glitch", (i < 3), 1'b0, 1'b0, 3'b000, 3'b000);

      // bounce 1,0,1,0 then settle high: last 0->1 is at step 4, pulse at step 9
      for (int i = 0; i < 12; i++)
         step("bounce", (i >= 4) ? 1'b1 : ((i % 2) == 0), 1'b0, 1'b0,
              {i >= 9, i == 9, 1'b0}, 3'b000);

      for (int i = 0; i < 8; i++)
         step("fall2", 1'b0, 1'b0, 1'b0, {i < 5, 1'b0, i == 5}, 3'b000);

      // reset at edge 4 aborts the count; rise 6 edges after release
      for (int i = 0; i < 13; i++)
         step("rst_mid", 1'b1, 1'b0, (i == 4), {i >= 10, i == 10, 1'b0}, 3'b000);

      // reset on the completing edge wins: no fall pulse
      for (int i = 0; i < 9; i++)
         step("rst_prio", 1'b0, 1'b0, (i == 5), {i < 5, 1'b0, 1'b0}, 3'b000);

      // minimum STABLE_CYCLES=2: clean step lands after edge 3
      for (int i = 0; i < 6; i++)
         step("min_rise", 1'b0, 1'b1, 1'b0, 3'b000, {i >= 3, i == 3, 1'b0});
      for (int i = 0; i < 6; i++)
         step("min_lo_pulse", 1'b0, (i != 0), 1'b0, 3'b000, 3'b100);
      for (int i = 0; i < 6; i++)
         step("min_fall", 1'b0, 1'b0, 1'b0, 3'b000, {i < 3, 1'b0, i == 3});
      for (int i = 0; i < 6; i++)
         step("min_hi_pulse", 1'b0, (i == 0), 1'b0, 3'b000, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
